// File: rtl/img_sobel_pipe_if.sv
// Bus-side strobes and data between the image controller and the Sobel datapath.
interface img_sobel_pipe_if #(
    parameter int PIX_W = 8
);
    logic [4*PIX_W-1:0] bus_dat_i;
    logic               load0;
    logic               load1;
    logic               load2;
    logic               en_pipe;
    logic               rst_a;
    logic [4*PIX_W-1:0] bus_dat_o;
    logic               res_valid;

    modport master (
        output bus_dat_i, load0, load1, load2, en_pipe, rst_a,
        input  bus_dat_o, res_valid
    );

    modport slave (
        input  bus_dat_i, load0, load1, load2, en_pipe, rst_a,
        output bus_dat_o, res_valid
    );
endinterface

// File: rtl/img_sobel_pipe.sv
// Three-row 3x3 Sobel window; packs four saturated (or thresholded)
// magnitudes into one bus word per four en_pipe cycles.
module img_sobel_pipe #(
    parameter int PIX_W  = 8,
    parameter int THRESH = 0
) (
    input logic             clk,
    input logic             rst_n,
    img_sobel_pipe_if.slave bus
);
    localparam int WORD_W = 4 * PIX_W;
    localparam int SUM_W  = PIX_W + 2;
    localparam int DIF_W  = PIX_W + 3;
    localparam logic [DIF_W-1:0] PIX_MAX = DIF_W'((1 << PIX_W) - 1);

    logic [WORD_W-1:0]  h_q [3];
    logic [PIX_W-1:0]   w_q [3][3];
    logic [1:0]         slot_q;
    logic [3*PIX_W-1:0] acc_q;
    logic [WORD_W-1:0]  dat_o_q;
    logic               valid_q;

    logic [2:0]              load;
    logic [SUM_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [DIF_W-1:0] gx, gy;
    logic [DIF_W-1:0]        ax, ay, mag;
    logic [PIX_W-1:0]        sat, result;
    logic                    fire;

    assign load = {bus.load2, bus.load1, bus.load0};
    assign fire = bus.en_pipe && !bus.rst_a && (slot_q == 2'd3);

    // Sobel magnitude on the window as it stands before this cycle's shift.
    always_comb begin
        gx_pos = SUM_W'(w_q[0][2]) + {1'b0, w_q[1][2], 1'b0} + SUM_W'(w_q[2][2]);
        gx_neg = SUM_W'(w_q[0][0]) + {1'b0, w_q[1][0], 1'b0} + SUM_W'(w_q[2][0]);
        gy_pos = SUM_W'(w_q[2][0]) + {1'b0, w_q[2][1], 1'b0} + SUM_W'(w_q[2][2]);
        gy_neg = SUM_W'(w_q[0][0]) + {1'b0, w_q[0][1], 1'b0} + SUM_W'(w_q[0][2]);
        gx     = signed'(DIF_W'(gx_pos)) - signed'(DIF_W'(gx_neg));
        gy     = signed'(DIF_W'(gy_pos)) - signed'(DIF_W'(gy_neg));
        ax     = $unsigned(gx[DIF_W-1] ? -gx : gx);
        ay     = $unsigned(gy[DIF_W-1] ? -gy : gy);
        mag    = ax + ay;
        sat    = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
        if (THRESH == 0) begin
            result = sat;
        end else begin
            result = (mag >= DIF_W'(THRESH)) ? '1 : '0;
        end
    end

    // Row holding registers; each load strobe captures independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '{default: '0};
        end else begin
            for (int unsigned r = 0; r < 3; r++) begin
                if (load[r]) h_q[r] <= bus.bus_dat_i;
            end
        end
    end

    // Window shift, slot counter and partial-word accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q    <= '{default: '{default: '0}};
            slot_q <= '0;
            acc_q  <= '0;
        end else if (bus.rst_a) begin
            w_q    <= '{default: '{default: '0}};
            slot_q <= '0;
            acc_q  <= '0;
        end else if (bus.en_pipe) begin
            for (int unsigned r = 0; r < 3; r++) begin
                w_q[r][0] <= w_q[r][1];
                w_q[r][1] <= w_q[r][2];
                w_q[r][2] <= h_q[r][PIX_W*slot_q +: PIX_W];
            end
            slot_q <= slot_q + 2'd1;
            case (slot_q)
                2'd0:    acc_q[PIX_W-1:0]         <= result;
                2'd1:    acc_q[2*PIX_W-1:PIX_W]   <= result;
                2'd2:    acc_q[3*PIX_W-1:2*PIX_W] <= result;
                default: ;
            endcase
        end
    end

    // Output word and its one-cycle valid pulse on the slot-3 shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_o_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= fire;
            if (fire) dat_o_q <= {result, acc_q};
        end
    end

    assign bus.bus_dat_o = dat_o_q;
    assign bus.res_valid = valid_q;
endmodule

// File: tb/tb_img_sobel_pipe.sv
// Bench for img_sobel_pipe: two instances (THRESH=0 and THRESH=9) share one
// stimulus stream and are checked every cycle against a column-history model.
module tb_img_sobel_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    img_sobel_pipe_if #(.PIX_W(8)) if0 ();
    img_sobel_pipe_if #(.PIX_W(8)) if9 ();

    assign if9.bus_dat_i = if0.bus_dat_i;
    assign if9.load0     = if0.load0;
    assign if9.load1     = if0.load1;
    assign if9.load2     = if0.load2;
    assign if9.en_pipe   = if0.en_pipe;
    assign if9.rst_a     = if0.rst_a;

    img_sobel_pipe #(.PIX_W(8), .THRESH(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    img_sobel_pipe #(.PIX_W(8), .THRESH(9)) dut9 (.clk(clk), .rst_n(rst_n), .bus(if9.slave));

    // Reference model: rows held as words, columns fed so far kept as a history.
    logic [31:0] mh [3];
    logic [23:0] hist [$];
    int          cnt;
    int          mags [4];
    logic [31:0] e_out0, e_out9;
    logic        e_val;

    function automatic int sobel_mag(input logic [23:0] c0, input logic [23:0] c1,
                                     input logic [23:0] c2);
        int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        logic [23:0] cols [3];
        int gx, gy, p;
        cols = '{c0, c1, c2};
        gx = 0;
        gy = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p  = int'(cols[c][8*r +: 8]);
                gx += kx[r][c] * p;
                gy += ky[r][c] * p;
            end
        end
        return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    endfunction

    function automatic logic [31:0] pack(input int th);
        logic [31:0] w;
        int v;
        w = '0;
        for (int s = 0; s < 4; s++) begin
            if (th == 0) v = (mags[s] > 255) ? 255 : mags[s];
            else         v = (mags[s] >= th) ? 255 : 0;
            w[8*s +: 8] = 8'(v);
        end
        return w;
    endfunction

    task automatic model_restart();
        hist = '{24'h0, 24'h0, 24'h0};
        cnt  = 0;
    endtask

    task automatic model_reset();
        mh     = '{default: 32'h0};
        mags   = '{default: 0};
        e_out0 = '0;
        e_out9 = '0;
        e_val  = 1'b0;
        model_restart();
    endtask

    task automatic model_step(input logic l0, input logic l1, input logic l2,
                              input logic en, input logic ra, input logic [31:0] d);
        logic [2:0]  ld;
        logic [23:0] col;
        int s;
        ld    = {l2, l1, l0};
        e_val = 1'b0;
        if (ra) begin
            model_restart();
        end else if (en) begin
            s = cnt % 4;
            mags[s] = sobel_mag(hist[0], hist[1], hist[2]);
            if (s == 3) begin
                e_out0 = pack(0);
                e_out9 = pack(9);
                e_val  = 1'b1;
            end
            col = {mh[2][8*s +: 8], mh[1][8*s +: 8], mh[0][8*s +: 8]};
            hist.push_back(col);
            void'(hist.pop_front());
            cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            if (ld[i]) mh[i] = d;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic l0, input logic l1, input logic l2,
                        input logic en, input logic ra, input logic [31:0] d);
        if0.load0     = l0;
        if0.load1     = l1;
        if0.load2     = l2;
        if0.en_pipe   = en;
        if0.rst_a     = ra;
        if0.bus_dat_i = d;
        @(posedge clk);
        model_step(l0, l1, l2, en, ra, d);
        #1;
        if (if0.res_valid === 1'b1) pulses++;
        check("valid_t0", 32'(if0.res_valid), 32'(e_val));
        check("dout_t0", if0.bus_dat_o, e_out0);
        check("valid_t9", 32'(if9.res_valid), 32'(e_val));
        check("dout_t9", if9.bus_dat_o, e_out9);
    endtask

    task automatic en_n(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic load_all(input logic [31:0] d);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic restart();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        if0.load0 = 1'b0; if0.load1 = 1'b0; if0.load2 = 1'b0;
        if0.en_pipe = 1'b0; if0.rst_a = 1'b0; if0.bus_dat_i = '0;
        model_reset();
        #12 rst_n = 1'b1;
        check("reset_dout", if0.bus_dat_o, 32'h0);
        check("reset_valid", 32'(if0.res_valid), 32'h0);

        // Async reset in the middle of a burst
        restart();
        load_all($urandom);
        en_n(8);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_dout", if0.bus_dat_o, 32'h0);
        check("async_valid", 32'(if0.res_valid), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        idle(2);
        en_n(2);
        check("async_no_pulse", 32'(pulses), 32'h0);

        // Flat image
        restart();
        load_all(32'h5A5A5A5A);
        pulses = 0;
        en_n(8);
        check("flat_pulses", 32'(pulses), 32'd2);
        check("flat_word", if0.bus_dat_o, 32'h00000000);

        // Vertical edge
        restart();
        load_all(32'h00000000);
        en_n(4);
        load_all(32'hFFFFFFFF);
        en_n(4);
        check("edge_word", if0.bus_dat_o, 32'h00FFFF00);
        check("edge_thr9", if9.bus_dat_o, 32'h00FFFF00);

        // Ramp
        restart();
        load_all(32'h03020100);
        en_n(8);
        check("ramp_word", if0.bus_dat_o, 32'h08080808);
        check("ramp_thr9", if9.bus_dat_o, 32'h00000000);

        // Split bursts give the same word as contiguous ones
        restart();
        load_all(32'h03020100);
        for (int b = 0; b < 2; b++) begin
            en_n(2);
            idle(3);
            en_n(2);
        end
        check("split_word", if0.bus_dat_o, 32'h08080808);

        // load0 on the same edge as the first shift
        restart();
        load_all(32'h00000000);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
        en_n(3);
        check("load_shift_word", if0.bus_dat_o, 32'hFFFF0000);

        // rst_a mid-burst, coincident with en_pipe
        restart();
        load_all($urandom);
        en_n(2);
        pulses = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        en_n(3);
        check("rsta_no_pulse", 32'(pulses), 32'h0);
        en_n(1);
        check("rsta_pulse", 32'(pulses), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
